// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// =============================================================================
// cpu_bus_pkg: shared bus-cycle state encoding and captured request record
// Revision: 1.0
// =============================================================================
package cpu_bus_pkg;

  localparam int CPU_BUS_ADDR_WIDTH = 20;
  localparam int CPU_BUS_DATA_WIDTH = 8;

  typedef logic [2:0] cpu_bus_state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_TW   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;
  localparam logic [2:0] ST_HOLD = 3'd6;

  // Request fields are held at the package widths; wider instances truncate.
  typedef struct packed {
    logic                          io;
    logic                          write;
    logic [CPU_BUS_ADDR_WIDTH-1:0] address;
    logic [CPU_BUS_DATA_WIDTH-1:0] wdata;
  } cpu_bus_req_t;

  function automatic logic in_wait_phase(input cpu_bus_state_t s);
    return (s == ST_T3) || (s == ST_TW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_bus_cycle_generator.sv
`default_nettype none
// =============================================================================
// cpu_bus_cycle_generator: 8088-style bus initiator (T1-T4, TW, HOLD/HLDA).
// BUS_IO_WAIT_EN adds IO_WAIT_STATES forced TW states to I/O cycles.
// Revision: 1.0
// =============================================================================
module cpu_bus_cycle_generator
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = CPU_BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH     = CPU_BUS_DATA_WIDTH,
  parameter int IO_WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_clock_posedge,
  input  logic                  cpu_clock_negedge,
  input  logic                  req,
  input  logic                  req_io,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  READY,
  input  logic                  HOLD,
  output logic                  HLDA,
  output logic                  ALE,
  output logic                  RD_N,
  output logic                  WR_N,
  output logic                  IO_OR_M,
  output logic                  DT_OR_R,
  output logic                  DEN_N,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  bus_oe
);

  cpu_bus_state_t        state_q, state_d;
  cpu_bus_req_t          req_q, req_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  hlda_q, hlda_d;
  logic                  ale_q, ale_d;
  logic                  rd_n_q, rd_n_d;
  logic                  wr_n_q, wr_n_d;
  logic                  dt_or_r_q, dt_or_r_d;
  logic                  den_n_q, den_n_d;
  logic                  bus_oe_q, bus_oe_d;
  logic                  ready_q, ready_d;
  logic                  start_cycle;
  logic                  enter_hold;
  logic                  forced_wait;

`ifdef BUS_IO_WAIT_EN
  localparam int WAIT_CNT_W = (IO_WAIT_STATES > 1) ? $clog2(IO_WAIT_STATES + 1) : 1;

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign forced_wait = (wait_cnt_q != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (cpu_clock_negedge) begin
      if (start_cycle) begin
        wait_cnt_d = req_io ? WAIT_CNT_W'(IO_WAIT_STATES) : '0;
      end else if (in_wait_phase(state_q) && forced_wait) begin
        wait_cnt_d = wait_cnt_q - 1'b1;
      end
    end
  end
`else
  assign forced_wait = 1'b0;

  // The forced-wait count only matters when the I/O wait feature is built in.
  if (IO_WAIT_STATES < 0) begin : g_io_wait_unused
  end
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    hlda_d      = hlda_q;
    ale_d       = ale_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    dt_or_r_d   = dt_or_r_q;
    den_n_d     = den_n_q;
    bus_oe_d    = bus_oe_q;
    ready_d     = ready_q;
    start_cycle = 1'b0;
    enter_hold  = 1'b0;

    // A coincident posedge enable is ignored: the negedge action wins.
    if (cpu_clock_negedge) begin
      case (state_q)
        ST_IDLE: begin
          if (HOLD) begin
            enter_hold = 1'b1;
          end else if (req) begin
            start_cycle = 1'b1;
          end
        end
        ST_T1: begin
          state_d = ST_T2;
          ale_d   = 1'b0;
          den_n_d = 1'b0;
          if (req_q.write) begin
            wr_n_d = 1'b0;
          end else begin
            rd_n_d = 1'b0;
          end
        end
        ST_T2: begin
          state_d = ST_T3;
          ready_d = 1'b0;
        end
        ST_T3, ST_TW: begin
          if (forced_wait) begin
            state_d = ST_TW;
            ready_d = 1'b0;
          end else if (ready_q) begin
            state_d = ST_T4;
            rd_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            ack_d   = 1'b1;
            if (!req_q.write) begin
              rdata_d = data_in;
            end
          end else begin
            state_d = ST_TW;
            ready_d = 1'b0;
          end
        end
        ST_T4: begin
          den_n_d = 1'b1;
          if (HOLD) begin
            enter_hold = 1'b1;
          end else if (req) begin
            start_cycle = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            dt_or_r_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!HOLD) begin
            state_d  = ST_IDLE;
            hlda_d   = 1'b0;
            bus_oe_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (enter_hold) begin
        state_d  = ST_HOLD;
        hlda_d   = 1'b1;
        bus_oe_d = 1'b0;
        ale_d    = 1'b0;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        den_n_d  = 1'b1;
      end

      if (start_cycle) begin
        state_d       = ST_T1;
        req_d.io      = req_io;
        req_d.write   = req_write;
        req_d.address = CPU_BUS_ADDR_WIDTH'(req_address);
        req_d.wdata   = CPU_BUS_DATA_WIDTH'(req_wdata);
        ale_d         = 1'b1;
        dt_or_r_d     = req_write;
      end
    end else if (cpu_clock_posedge) begin
      if (state_q == ST_T1) begin
        ale_d = 1'b0;
      end
      if (state_q == ST_T4) begin
        den_n_d = 1'b1;
      end
      if (in_wait_phase(state_q)) begin
        ready_d = READY;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      hlda_q    <= 1'b0;
      ale_q     <= 1'b0;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      dt_or_r_q <= 1'b1;
      den_n_q   <= 1'b1;
      bus_oe_q  <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      hlda_q    <= hlda_d;
      ale_q     <= ale_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      dt_or_r_q <= dt_or_r_d;
      den_n_q   <= den_n_d;
      bus_oe_q  <= bus_oe_d;
      ready_q   <= ready_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign HLDA        = hlda_q;
  assign ALE         = ale_q;
  assign RD_N        = rd_n_q;
  assign WR_N        = wr_n_q;
  assign IO_OR_M     = req_q.io;
  assign DT_OR_R     = dt_or_r_q;
  assign DEN_N       = den_n_q;
  assign address_out = ADDR_WIDTH'(req_q.address);
  assign data_out    = DATA_WIDTH'(req_q.wdata);
  assign bus_oe      = bus_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_cycle_generator.sv
`default_nettype none
// =============================================================================
// tb_cpu_bus_cycle_generator: randomized bus-cycle schedule against a timeline
// model of expected strobe/status levels per CPU half-clock. Revision: 1.0
// =============================================================================
module tb_cpu_bus_cycle_generator;

  localparam int AW   = 20;
  localparam int DW   = 8;
  localparam int IOW  = 1;
  localparam int MAXE = 1024;
  localparam int MAXS = 2 * MAXE + 8;
  localparam int NT   = 48;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_clock_posedge = 1'b0;
  logic          cpu_clock_negedge = 1'b0;
  logic          req = 1'b0;
  logic          req_io = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] data_in = '0;
  logic          READY = 1'b1;
  logic          HOLD = 1'b0;
  logic          ack, HLDA, ALE, RD_N, WR_N, IO_OR_M, DT_OR_R, DEN_N, bus_oe;
  logic [DW-1:0] rdata, data_out;
  logic [AW-1:0] address_out;

  cpu_bus_cycle_generator #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .IO_WAIT_STATES(IOW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_clock_posedge(cpu_clock_posedge),
    .cpu_clock_negedge(cpu_clock_negedge),
    .req              (req),
    .req_io           (req_io),
    .req_write        (req_write),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .ack              (ack),
    .rdata            (rdata),
    .READY            (READY),
    .HOLD             (HOLD),
    .HLDA             (HLDA),
    .ALE              (ALE),
    .RD_N             (RD_N),
    .WR_N             (WR_N),
    .IO_OR_M          (IO_OR_M),
    .DT_OR_R          (DT_OR_R),
    .DEN_N            (DEN_N),
    .address_out      (address_out),
    .data_out         (data_out),
    .data_in          (data_in),
    .bus_oe           (bus_oe)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-negedge stimulus (index e = CPU clock number)
  logic          ready_at[MAXE], hold_at[MAXE], req_at[MAXE], io_at[MAXE], wr_at[MAXE], ack_at[MAXE];
  logic [AW-1:0] addr_at[MAXE];
  logic [DW-1:0] wdata_at[MAXE], din_at[MAXE];

  // Expected levels per half-clock slot: 2e after posedge e, 2e+1 after negedge e
  logic          e_ale[MAXS], e_rd[MAXS], e_wr[MAXS], e_den[MAXS], e_hlda[MAXS];
  logic          e_oe[MAXS], e_dt[MAXS], e_io[MAXS];
  logic [AW-1:0] e_addr[MAXS];
  logic [DW-1:0] e_dout[MAXS], e_rdata[MAXS];

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_ALE"},   32'(ALE),         32'd0);
    check_val({pfx, "_RD_N"},  32'(RD_N),        32'd1);
    check_val({pfx, "_WR_N"},  32'(WR_N),        32'd1);
    check_val({pfx, "_DEN_N"}, 32'(DEN_N),       32'd1);
    check_val({pfx, "_DT"},    32'(DT_OR_R),     32'd1);
    check_val({pfx, "_IO"},    32'(IO_OR_M),     32'd0);
    check_val({pfx, "_HLDA"},  32'(HLDA),        32'd0);
    check_val({pfx, "_OE"},    32'(bus_oe),      32'd1);
    check_val({pfx, "_ACK"},   32'(ack),         32'd0);
    check_val({pfx, "_RDATA"}, 32'(rdata),       32'd0);
    check_val({pfx, "_ADDR"},  32'(address_out), 32'd0);
    check_val({pfx, "_DOUT"},  32'(data_out),    32'd0);
  endtask

  task automatic check_slot(input int s);
    check_val("ALE",   32'(ALE),         32'(e_ale[s]));
    check_val("RD_N",  32'(RD_N),        32'(e_rd[s]));
    check_val("WR_N",  32'(WR_N),        32'(e_wr[s]));
    check_val("DEN_N", 32'(DEN_N),       32'(e_den[s]));
    check_val("HLDA",  32'(HLDA),        32'(e_hlda[s]));
    check_val("OE",    32'(bus_oe),      32'(e_oe[s]));
    check_val("DT",    32'(DT_OR_R),     32'(e_dt[s]));
    check_val("IO",    32'(IO_OR_M),     32'(e_io[s]));
    check_val("ADDR",  32'(address_out), 32'(e_addr[s]));
    check_val("DOUT",  32'(data_out),    32'(e_dout[s]));
    check_val("RDATA", 32'(rdata),       32'(e_rdata[s]));
  endtask

  int acks_seen;

  task automatic cpu_period();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (ack) acks_seen++;
      cpu_clock_posedge = (i == 0);
      cpu_clock_negedge = (i == 2);
    end
  endtask

  int e, c, r, f, w, fin, n, mode, h, g, etot, s;

  initial begin
    // ---------------- reset values and reset in the middle of a cycle ----------
    repeat (2) @(negedge clock);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clock);
    req = 1'b1; req_io = 1'b0; req_write = 1'b0; req_address = 20'h12345; READY = 1'b0;
    acks_seen = 0;
    for (int p = 0; p < 7; p++) cpu_period();
    check_val("tw_RD_N", 32'(RD_N), 32'd0);
    check_val("tw_DEN_N", 32'(DEN_N), 32'd0);
    check_val("tw_ADDR", 32'(address_out), 32'h12345);
    #1 reset = 1'b1;
    #1 check_reset_values("midrst");
    repeat (3) begin
      @(negedge clock);
      if (ack) acks_seen++;
    end
    reset = 1'b0;
    req = 1'b0;
    READY = 1'b1;
    for (int p = 0; p < 4; p++) cpu_period();
    check_val("midrst_no_ack", 32'(acks_seen), 32'd0);
    check_val("midrst_idle_RD_N", 32'(RD_N), 32'd1);
    cpu_clock_posedge = 1'b0;
    cpu_clock_negedge = 1'b0;

    // ---------------- build randomized schedule and expected timeline ----------
    for (int i = 0; i < MAXE; i++) begin
      ready_at[i] = 1'($urandom);
      hold_at[i]  = 1'($urandom);
      req_at[i]   = 1'($urandom);
      io_at[i]    = 1'($urandom);
      wr_at[i]    = 1'($urandom);
      addr_at[i]  = AW'($urandom);
      wdata_at[i] = DW'($urandom);
      din_at[i]   = DW'($urandom);
      ack_at[i]   = 1'b0;
    end
    for (int i = 0; i < MAXS; i++) begin
      e_ale[i] = 1'b0; e_rd[i] = 1'b1; e_wr[i] = 1'b1; e_den[i] = 1'b1; e_hlda[i] = 1'b0;
      e_oe[i] = 1'b1; e_dt[i] = 1'b1; e_io[i] = 1'b0; e_addr[i] = '0; e_dout[i] = '0;
      e_rdata[i] = '0;
    end
    req_at[0] = 1'b0; hold_at[0] = 1'b0;
    e = 1;
    for (int t = 0; t < NT; t++) begin
      c = e;
      req_at[c]  = 1'b1;
      hold_at[c] = 1'b0;
      r    = int'($urandom_range(0, 2));
      mode = int'($urandom_range(0, 2));
      case (t)
        0: begin io_at[c] = 1'b0; wr_at[c] = 1'b0; addr_at[c] = 20'hF0000; r = 0; mode = 0; end
        1: begin io_at[c] = 1'b1; wr_at[c] = 1'b1; addr_at[c] = 20'h00060; wdata_at[c] = 8'hA5; r = 0; mode = 0; end
        2: begin io_at[c] = 1'b0; wr_at[c] = 1'b0; r = 2; mode = 0; end
        3: begin io_at[c] = 1'b0; wr_at[c] = 1'b1; r = 0; mode = 2; end
        4: begin io_at[c] = 1'b0; wr_at[c] = 1'b0; r = 0; mode = 1; end
        5: begin io_at[c] = 1'b0; wr_at[c] = 1'b0; r = 0; mode = 0; end
        default: ;
      endcase
      if (t == NT - 1 && mode == 1) mode = 0;
`ifdef BUS_IO_WAIT_EN
      f = io_at[c] ? IOW : 0;
`else
      f = 0;
`endif
      w = f + r;
      for (int j = 0; j <= r; j++) ready_at[c + 3 + f + j] = (j == r);
      fin = c + 3 + w;
      if (t == 0) din_at[fin] = 8'h5A;
      if (t == 3) for (int x = c + 1; x <= fin; x++) hold_at[x] = 1'b1;
      ack_at[fin] = 1'b1;
      e_ale[2 * c + 1] = 1'b1;
      for (int x = 2 * c + 3; x <= 2 * fin; x++) begin
        if (wr_at[c]) e_wr[x] = 1'b0;
        else          e_rd[x] = 1'b0;
      end
      for (int x = 2 * c + 3; x <= 2 * fin + 1; x++) e_den[x] = 1'b0;
      for (int x = 2 * c + 1; x < MAXS; x++) begin
        e_dt[x] = wr_at[c]; e_io[x] = io_at[c]; e_addr[x] = addr_at[c]; e_dout[x] = wdata_at[c];
      end
      if (!wr_at[c]) for (int x = 2 * fin + 1; x < MAXS; x++) e_rdata[x] = din_at[fin];
      n = fin + 1;
      if (mode == 1) begin
        e = n;
      end else begin
        if (mode == 2) begin
          h = int'($urandom_range(1, 3));
          for (int x = n; x < n + h; x++) hold_at[x] = 1'b1;
          hold_at[n + h] = 1'b0;
          for (int x = 2 * n + 1; x <= 2 * (n + h); x++) begin
            e_hlda[x] = 1'b1; e_oe[x] = 1'b0;
          end
          n = n + h;
        end else begin
          req_at[n] = 1'b0; hold_at[n] = 1'b0;
          for (int x = 2 * n + 1; x < MAXS; x++) e_dt[x] = 1'b1;
        end
        g = int'($urandom_range(1, 3));
        for (int x = n + 1; x < n + g; x++) begin
          req_at[x] = 1'b0; hold_at[x] = 1'b0;
        end
        e = n + g;
      end
    end
    for (int x = e; x < e + 6; x++) begin
      req_at[x] = 1'b0; hold_at[x] = 1'b0;
    end
    etot = e + 5;

    // ---------------- run the schedule ----------------
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 4 * etot; k++) begin
      @(negedge clock);
      if (k > 0) begin
        s = (k - 1) >> 1;
        check_slot(s);
        check_val("ACK", 32'(ack), ((k - 1) % 4 == 2) ? 32'(ack_at[(k - 1) / 4]) : 32'd0);
      end
      cpu_clock_posedge = (k % 4 == 0);
      cpu_clock_negedge = (k % 4 == 2);
      if (k % 4 == 0) begin
        READY       = ready_at[k / 4];
        HOLD        = hold_at[k / 4];
        req         = req_at[k / 4];
        req_io      = io_at[k / 4];
        req_write   = wr_at[k / 4];
        req_address = addr_at[k / 4];
        req_wdata   = wdata_at[k / 4];
        data_in     = din_at[k / 4];
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
